// File: rtl/alu_ctrl_stage_if.sv
// Bus between the controller/hazard unit (master) and alu_ctrl_stage (slave):
// D-stage instruction and stall/flush controls in, E-stage ALU code and HI/LO sequencer status out.
interface alu_ctrl_stage_if #(
  parameter int CTRL_W = 8
);
  logic              stallD;
  logic              stallE;
  logic              flushE;
  logic [31:0]       instrD;
  logic              invalidD;
  logic [CTRL_W-1:0] alucontrolE;
  logic              riE;
  logic              md_start;
  logic              md_done;
  logic              md_busy;
  logic              md_stall_req;

  modport master (
    output stallD, stallE, flushE, instrD,
    input  invalidD, alucontrolE, riE, md_start, md_done, md_busy, md_stall_req
  );

  modport slave (
    input  stallD, stallE, flushE, instrD,
    output invalidD, alucontrolE, riE, md_start, md_done, md_busy, md_stall_req
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// D-stage ALU decode registered into E (1 cycle, stall/flush) plus a HI/LO occupancy sequencer.
// Optional macro ALUCTRL_RI_EXC_EN registers the reserved-instruction flag into riE.
module alu_ctrl_stage #(
  parameter int CTRL_W      = 8,
  parameter int MULT_CYCLES = 2,
  parameter int DIV_CYCLES  = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_stage_if.slave  bus
);

  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_ANDI_OP  = 8'b0101_1001;
  localparam logic [7:0] EXE_ORI_OP   = 8'b0101_1010;
  localparam logic [7:0] EXE_XORI_OP  = 8'b0101_1011;
  localparam logic [7:0] EXE_LUI_OP   = 8'b0101_1100;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SLLV_OP  = 8'b0000_0100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRLV_OP  = 8'b0000_0110;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_SRAV_OP  = 8'b0000_0111;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_SLTI_OP  = 8'b0101_0111;
  localparam logic [7:0] EXE_SLTIU_OP = 8'b0101_1000;
  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
  localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_JALR_OP  = 8'b0000_1001;
  localparam logic [7:0] EXE_JAL_OP   = 8'b0101_0000;

  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W  = (MD_MAX > 1) ? $clog2(MD_MAX) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} md_state_e;

  logic [5:0] op;
  logic [5:0] funct;
  logic [7:0] dec_code;
  logic       dec_inv;
  logic       hilo_user_d;

  assign op    = bus.instrD[31:26];
  assign funct = bus.instrD[5:0];

  always_comb begin
    dec_code = 8'h00;
    dec_inv  = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h24: dec_code = EXE_AND_OP;
          6'h25: dec_code = EXE_OR_OP;
          6'h26: dec_code = EXE_XOR_OP;
          6'h27: dec_code = EXE_NOR_OP;
          6'h20: dec_code = EXE_ADD_OP;
          6'h22: dec_code = EXE_SUB_OP;
          6'h21: dec_code = EXE_ADDU_OP;
          6'h23: dec_code = EXE_SUBU_OP;
          6'h2A: dec_code = EXE_SLT_OP;
          6'h2B: dec_code = EXE_SLTU_OP;
          6'h18: dec_code = EXE_MULT_OP;
          6'h19: dec_code = EXE_MULTU_OP;
          6'h1A: dec_code = EXE_DIV_OP;
          6'h1B: dec_code = EXE_DIVU_OP;
          6'h11: dec_code = EXE_MTHI_OP;
          6'h13: dec_code = EXE_MTLO_OP;
          6'h10: dec_code = EXE_MFHI_OP;
          6'h12: dec_code = EXE_MFLO_OP;
          6'h00: dec_code = EXE_SLL_OP;
          6'h02: dec_code = EXE_SRL_OP;
          6'h03: dec_code = EXE_SRA_OP;
          6'h04: dec_code = EXE_SLLV_OP;
          6'h06: dec_code = EXE_SRLV_OP;
          6'h07: dec_code = EXE_SRAV_OP;
          6'h09: dec_code = EXE_JALR_OP;
          default: dec_inv = 1'b1;
        endcase
      end
      6'h0C: dec_code = EXE_ANDI_OP;
      6'h0D: dec_code = EXE_ORI_OP;
      6'h0E: dec_code = EXE_XORI_OP;
      6'h0F: dec_code = EXE_LUI_OP;
      6'h08: dec_code = EXE_ADDI_OP;
      6'h09: dec_code = EXE_ADDIU_OP;
      6'h0A: dec_code = EXE_SLTI_OP;
      6'h0B: dec_code = EXE_SLTIU_OP;
      6'h23, 6'h2B: dec_code = EXE_ADD_OP;
      6'h02, 6'h04: dec_code = EXE_ADDU_OP;
      6'h03: dec_code = EXE_JAL_OP;
      default: dec_inv = 1'b1;
    endcase
  end

  always_comb begin
    hilo_user_d = 1'b0;
    if (op == 6'h00) begin
      case (funct)
        6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13: hilo_user_d = 1'b1;
        default: hilo_user_d = 1'b0;
      endcase
    end
  end

  // The decode is deliberately blind to stallD and to the rs/rt/rd/shamt fields.
  logic unused_ok;
  assign unused_ok = ^{bus.stallD, bus.instrD[25:6]};

  // E register: rst > flushE > stallE > load.
  logic [CTRL_W-1:0] alu_q, alu_d;
  logic              e_update;

  assign e_update = bus.flushE | ~bus.stallE;

  always_comb begin
    alu_d = alu_q;
    if (bus.flushE)       alu_d = '0;
    else if (!bus.stallE) alu_d = CTRL_W'(dec_code);
  end

  always_ff @(posedge clk) begin
    if (rst) alu_q <= '0;
    else     alu_q <= alu_d;
  end

  assign bus.alucontrolE = alu_q;
  assign bus.invalidD    = dec_inv;

`ifdef ALUCTRL_RI_EXC_EN
  logic ri_q, ri_d;

  always_comb begin
    ri_d = ri_q;
    if (bus.flushE)       ri_d = 1'b0;
    else if (!bus.stallE) ri_d = dec_inv;
  end

  always_ff @(posedge clk) begin
    if (rst) ri_q <= 1'b0;
    else     ri_q <= ri_d;
  end

  assign bus.riE = ri_q;
`else
  assign bus.riE = 1'b0;
`endif

  // HI/LO occupancy sequencer.
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             started_q, started_d;
  logic             is_mult_e, is_div_e;
  logic             md_start, md_done, md_busy;

  assign is_mult_e = (alu_q == CTRL_W'(EXE_MULT_OP)) || (alu_q == CTRL_W'(EXE_MULTU_OP));
  assign is_div_e  = (alu_q == CTRL_W'(EXE_DIV_OP))  || (alu_q == CTRL_W'(EXE_DIVU_OP));

  assign md_start = (state_q == IDLE) & (is_mult_e | is_div_e) & ~started_q;
  assign md_busy  = (state_q == BUSY);
  assign md_done  = md_busy & (count_q == '0);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    started_d = started_q;
    if (md_start) begin
      state_d   = BUSY;
      count_d   = is_div_e ? DIV_LOAD : MULT_LOAD;
      started_d = 1'b1;
    end else if (md_busy) begin
      if (count_q == '0) state_d = IDLE;
      else               count_d = count_q - CNT_W'(1);
    end
    // A new occupant of E (or a bubble) re-arms the launch.
    if (e_update) started_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      started_q <= started_d;
    end
  end

  assign bus.md_start     = md_start;
  assign bus.md_done      = md_done;
  assign bus.md_busy      = md_busy;
  assign bus.md_stall_req = hilo_user_d & (md_start | (md_busy & ~md_done));

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Registered successor to the D-stage ALU decoder.
- Decodes the D-stage instruction into an ALU control code and registers it into the E stage with stall and flush handling.
- Adds a multiply/divide occupancy sequencer that issues start/done pulses for the HI/LO unit and raises a stall request for dependent D-stage instructions.
- Flags undefined encodings.
- Sits between the controller/hazard unit and the E-stage ALU / HI-LO unit.

Parameters:
- CTRL_W, 8: width of ALU control code. Must be ≥ 8. The 8-bit EXE_*_OP codes from defines.vh are zero-extended to this width.
- MULT_CYCLES, 2: HI/LO unit occupancy for MULT/MULTU, in cycles. Must be ≥ 1.
- DIV_CYCLES, 32: HI/LO unit occupancy for DIV/DIVU, in cycles. Must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stallD  in  1  D stage held. The combinational decode ignores it.
- stallE  in  1  hold E register.
- flushE  in  1  clear E register (bubble).
- instrD  in  32  D-stage instruction.
- invalidD  out  1  combinational: op/funct not in decode table.
- alucontrolE  out  CTRL_W  registered E-stage ALU control.
- riE  out  1  registered reserved-instruction flag (see Optional Feature).
- md_start  out  1  one-cycle pulse: launch HI/LO operation for the instruction in E.
- md_done  out  1  one-cycle pulse: HI/LO result written this cycle.
- md_busy  out  1  sequencer in BUSY.
- md_stall_req  out  1  request hazard unit to stall D / flush E.

Behaviour:
Decode table (combinational):
- op=SPECIAL: AND, OR, XOR, NOR, ADD, SUB, ADDU, SUBU, SLT, SLTU, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, SLL, SRL, SRA, SLLV, SRLV, SRAV, JALR map to their EXE_*_OP codes.
- ANDI, ORI, XORI, LUI, ADDI, ADDIU, SLTI, SLTIU map to their own EXE_*_OP codes.
- LW, SW → ADD_OP.
- J, BEQ → ADDU_OP.
- JAL → JAL_OP.
- Anything else → 0, with invalidD=1.
- NOP (0x00000000) decodes as SLL, invalidD=0.

E register, priority rst > flushE > stallE > load:
- rst or flushE: alucontrolE=0.
- stallE: hold.
- Otherwise: load decoded code.
- Latency: D decode to alucontrolE is 1 cycle.

HI/LO user set (D): MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.

Sequencer states: IDLE, BUSY. Internal: count (width for max(MULT_CYCLES, DIV_CYCLES) − 1), started flag.
- md_start = IDLE & alucontrolE ∈ {MULT_OP, MULTU_OP, DIV_OP, DIVU_OP} & ~started.
- On md_start edge:
  - count ← N−1, with N = MULT_CYCLES for MULT/MULTU and DIV_CYCLES for DIV/DIVU.
  - state ← BUSY.
  - started ← 1.
- started clears whenever the E register loads or flushes, so a held (stallE) md op launches exactly once.
- In BUSY:
  - count≠0: decrement.
  - count==0: md_done=1 that cycle, state ← IDLE.
- Timing: start in cycle t gives done in cycle t+N. N=1 gives done at t+1.
- md_busy = (state==BUSY).
- md_stall_req = HI/LO user in D & (md_start | (md_busy & ~md_done)). It is not asserted in the done cycle, because the result is written at the end of that cycle.

Boundary conditions:
- flushE during BUSY does not abort; the operation was launched earlier and completes.
- flushE in the same cycle as md_start: start still issues, because the instruction was valid in E that cycle.
- An md op reaching E while BUSY cannot happen, because md_stall_req blocks it. If it does occur, it waits in E until IDLE with started=0, then starts.
- Reset mid-operation: state IDLE, count 0, started 0, no md_done emitted.

Reset values: alucontrolE=0, riE=0, md_busy=0, md_start=0, md_done=0, md_stall_req=0 (provided instrD is not a HI/LO user).

Optional Feature:
Macro ALUCTRL_RI_EXC_EN.
- Defined: riE follows the E register rules (rst/flush → 0, stall → hold, else ← invalidD). An invalid instruction is therefore reported in E alongside alucontrolE=0.
- Undefined: riE is tied 0 and no flop is inferred.
- invalidD is present in both cases.

Test Plan:
- Reset, then instrD=0x01094020 (ADD) with no stall/flush → next cycle alucontrolE=EXE_ADD_OP, invalidD=0.
- instrD=0x3C011234 (LUI), stallE=1 for 3 cycles with alucontrolE previously holding ADD_OP → alucontrolE stays ADD_OP; stallE=0 → LUI_OP next cycle. flushE=1 together with stallE=1 → 0.
- DIV (0x0109001A) reaches E with DIV_CYCLES=32 → md_start in cycle t only, md_busy from t+1, md_done exactly at t+32. MFLO held in D gives md_stall_req=1 for t..t+31 and 0 at t+32.
- MULT held in E by stallE for 4 cycles with MULT_CYCLES=2 → single md_start, md_done 2 cycles later.
- rst asserted at t+10 of a DIV → next cycle md_busy=0, no md_done; a subsequent MULTU starts normally.
- instrD=0xFC000000 (undefined op) → invalidD=1, alucontrolE=0 next cycle, riE=1 with ALUCTRL_RI_EXC_EN defined and riE=0 without.
